// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle.
// Single operation in flight with valid/ready on both sides.
module seq_divider #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_div0
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div;
  logic [TAG_W-1:0] tag;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  // trial[WIDTH] is the borrow: set when shifted < div
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, div};
    rem_nx  = trial[WIDTH-1:0];
    quo_nx  = {quo[WIDTH-2:0], 1'b1};
    if (trial[WIDTH]) begin
      rem_nx = shifted[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b0};
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      rem           <= '0;
      quo           <= '0;
      div           <= '0;
      tag           <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_tag       <= '0;
      out_div0      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            tag <= in_tag;
            if (in_divisor == '0) begin
              out_quotient  <= '1;
              out_remainder <= in_dividend;
              out_tag       <= in_tag;
              out_div0      <= 1'b1;
              state         <= DONE;
            end else begin
              rem   <= '0;
              quo   <= in_dividend;
              div   <= in_divisor;
              cnt   <= CW'(WIDTH);
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            out_quotient  <= quo_nx;
            out_remainder <= rem_nx;
            out_tag       <= tag;
            out_div0      <= 1'b0;
            state         <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
